// File: rtl/axi4lite_master_transactor_if.sv
// Bundle of the command, response and AXI4-Lite master signals for
// axi4lite_master_transactor.
//   master modport : the transactor's view. It takes commands, issues AXI4-Lite
//                    requests and returns responses.
//   slave  modport : the environment's view. It issues commands, models the
//                    AXI4-Lite slave and consumes responses.
// Parameters: dataWidth is the data bus width in bits (a multiple of 8), and
// addrWidth is the address width in bits.
interface axi4lite_master_transactor_if #(
  parameter int unsigned dataWidth = 32,
  parameter int unsigned addrWidth = 32
) ();
  // Command channel
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [addrWidth-1:0]   cmd_addr;
  logic [2:0]             cmd_prot;
  logic [dataWidth-1:0]   cmd_wdata;
  logic [dataWidth/8-1:0] cmd_wstrb;
  // Response channel
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_write;
  logic [1:0]             rsp_resp;
  logic [dataWidth-1:0]   rsp_rdata;
  logic                   rsp_timeout;
  // AXI4-Lite write address, write data and write response
  logic                   awvalid;
  logic                   awready;
  logic [addrWidth-1:0]   awaddr;
  logic [2:0]             awprot;
  logic                   wvalid;
  logic                   wready;
  logic [dataWidth-1:0]   wdata;
  logic [dataWidth/8-1:0] wstrb;
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             bresp;
  // AXI4-Lite read address and read data
  logic                   arvalid;
  logic                   arready;
  logic [addrWidth-1:0]   araddr;
  logic [2:0]             arprot;
  logic                   rvalid;
  logic                   rready;
  logic [dataWidth-1:0]   rdata;
  logic [1:0]             rresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_prot, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_resp, rsp_rdata, rsp_timeout,
    input  rsp_ready,
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_prot, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_resp, rsp_rdata, rsp_timeout,
    output rsp_ready,
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/axi4lite_master_transactor.sv
// AXI4-Lite master transactor. It accepts one command at a time, performs a
// single AXI4-Lite write or read, and returns the response on the response
// channel. Only one transaction is outstanding at any time.
// Ports:
//   clk : clock, active on the rising edge.
//   rst : asynchronous reset, active-high.
//   bus : axi4lite_master_transactor_if.master. It carries the command
//         channel (cmd_*), the response channel (rsp_*) and the AXI4-Lite
//         AW/W/B/AR/R master signals.
// Optional feature: when the macro AXI4LITE_TIMEOUT_EN is defined, a wait for
// B or R is abandoned after TIMEOUT cycles. The transactor then reports
// rsp_resp=2'b10 and rsp_timeout=1. When the macro is undefined, the
// transactor waits indefinitely and rsp_timeout is tied to 0.
module axi4lite_master_transactor #(
  parameter int unsigned dataWidth = 32,
  parameter int unsigned addrWidth = 32,
  parameter int unsigned TIMEOUT   = 256
) (
  input logic                         clk,
  input logic                         rst,
  axi4lite_master_transactor_if.master bus
);

  localparam int unsigned StrbWidth = dataWidth / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [addrWidth-1:0]   addr_q, addr_d;
  logic [2:0]             prot_q, prot_d;
  logic [dataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
  // AW and W handshakes complete independently in StWrReq.
  logic                   aw_pend_q, aw_pend_d;
  logic                   w_pend_q, w_pend_d;
  logic                   rsp_write_q, rsp_write_d;
  logic [1:0]             rsp_resp_q, rsp_resp_d;
  logic [dataWidth-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   aw_done, w_done;

`ifdef AXI4LITE_TIMEOUT_EN
  localparam int unsigned CntWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                timeout_hit;
  // The counter runs 0..TIMEOUT-1, so the ready output is held for TIMEOUT cycles.
  assign timeout_hit = (cnt_q == CntWidth'(TIMEOUT - 1));
`endif

  // A handshake counts as done if it completed earlier or completes this cycle.
  assign aw_done = !aw_pend_q || bus.awready;
  assign w_done  = !w_pend_q  || bus.wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    prot_d      = prot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef AXI4LITE_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          prot_d  = bus.cmd_prot;
          wdata_d = bus.cmd_wdata;
          wstrb_d = bus.cmd_wstrb;
          if (bus.cmd_write) begin
            state_d   = StWrReq;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StWrReq: begin
        if (aw_pend_q && bus.awready) aw_pend_d = 1'b0;
        if (w_pend_q && bus.wready)   w_pend_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d = StWrResp;
`ifdef AXI4LITE_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      StWrResp: begin
        if (bus.bvalid) begin
          state_d     = StDone;
          rsp_write_d = 1'b1;
          rsp_resp_d  = bus.bresp;
          rsp_rdata_d = '0;
`ifdef AXI4LITE_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = StDone;
          rsp_write_d   = 1'b1;
          rsp_resp_d    = 2'b10;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StRdReq: begin
        if (bus.arready) begin
          state_d = StRdResp;
`ifdef AXI4LITE_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      StRdResp: begin
        if (bus.rvalid) begin
          state_d     = StDone;
          rsp_write_d = 1'b0;
          rsp_resp_d  = bus.rresp;
          rsp_rdata_d = bus.rdata;
`ifdef AXI4LITE_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = StDone;
          rsp_write_d   = 1'b0;
          rsp_resp_d    = 2'b10;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      prot_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      prot_q      <= prot_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef AXI4LITE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  // cmd_ready is masked by rst so that it stays low during reset even though the state is StIdle.
  assign bus.cmd_ready = (state_q == StIdle) && !rst;

  // All valid outputs are decoded from registers only, so there is no combinational path from ready to valid.
  assign bus.awvalid = (state_q == StWrReq) && aw_pend_q;
  assign bus.wvalid  = (state_q == StWrReq) && w_pend_q;
  assign bus.bready  = (state_q == StWrResp);
  assign bus.arvalid = (state_q == StRdReq);
  assign bus.rready  = (state_q == StRdResp);

  assign bus.awaddr = addr_q;
  assign bus.awprot = prot_q;
  assign bus.araddr = addr_q;
  assign bus.arprot = prot_q;
  assign bus.wdata  = wdata_q;
  assign bus.wstrb  = wstrb_q;

  assign bus.rsp_valid = (state_q == StDone);
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/axi4lite_master_transactor.md
AXI4LITE_MASTER_TRANSACTOR -- requirements
Module: axi4lite_master_transactor

Interface
REQ-001 SHALL have parameter dataWidth, default 32, meaning the data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter addrWidth, default 32, meaning the address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 256, meaning the number of cycles to wait for B/R before abort (used only with AXI4LITE_TIMEOUT_EN).
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  asynchronous reset, active-high.
REQ-005 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write); cmd_addr in addrWidth; cmd_prot in 3; cmd_wdata in dataWidth; cmd_wstrb in dataWidth/8.
REQ-006 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_write out 1; rsp_resp out 2 (AXI encoding); rsp_rdata out dataWidth; rsp_timeout out 1.
REQ-007 SHALL have AXI4-Lite master write ports: awvalid out 1; awready in 1; awaddr out addrWidth; awprot out 3; wvalid out 1; wready in 1; wdata out dataWidth; wstrb out dataWidth/8; bvalid in 1; bready out 1; bresp in 2.
REQ-008 SHALL have AXI4-Lite master read ports: arvalid out 1; arready in 1; araddr out addrWidth; arprot out 3; rvalid in 1; rready out 1; rdata in dataWidth; rresp in 2.

Function
REQ-009 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; one transaction outstanding at a time.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&cmd_ready, and addr/prot/wdata/wstrb/write are registered that cycle.
REQ-011 On accepted write SHALL go to WR_REQ and assert awvalid and wvalid together on the next cycle, with registered payloads.
REQ-012 In WR_REQ, awvalid SHALL drop the cycle after the awready handshake and wvalid the cycle after the wready handshake, each independently tracked; the state SHALL advance to WR_RESP once both handshakes complete (same-cycle completion allowed).
REQ-013 In WR_RESP SHALL hold bready=1; on bvalid SHALL capture bresp, set rsp_write=1, and go to DONE.
REQ-014 On accepted read SHALL go to RD_REQ asserting arvalid until arready, then RD_RESP.
REQ-015 In RD_RESP SHALL hold rready=1; on rvalid SHALL capture rdata and rresp, set rsp_write=0, and go to DONE.
REQ-016 In DONE SHALL assert rsp_valid with stable rsp_* until rsp_ready, then return to IDLE; rsp_rdata SHALL be 0 for writes.
REQ-017 Once asserted, awvalid/wvalid/arvalid SHALL NOT deassert and payloads SHALL NOT change before the matching ready.
REQ-018 SHALL NOT depend on awready/wready/arready before asserting valid (no combinational ready-to-valid path).
REQ-019 Minimum latency SHALL be: command accept to rsp_valid = 3 cycles when the slave responds with zero-wait ready and B/R.
REQ-020 Back-to-back: cmd_ready SHALL reassert the cycle after the rsp handshake.

Reset
REQ-021 While rst=1 SHALL force state IDLE and all valid/ready outputs to 0; cmd_ready SHALL become 1 the first cycle after rst deasserts.
REQ-022 Reset SHALL clear addr/data/strb/prot/rsp_resp/rsp_rdata/rsp_timeout/rsp_write to 0 (no X values).
REQ-023 Reset mid-transaction SHALL abandon it with no response issued.

Configuration
REQ-024 With AXI4LITE_TIMEOUT_EN defined SHALL count cycles in WR_RESP/RD_RESP; on reaching TIMEOUT without bvalid/rvalid SHALL drop bready/rready, go to DONE with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
REQ-025 Without AXI4LITE_TIMEOUT_EN SHALL wait indefinitely, tie rsp_timeout to 0, and synthesize no counter.

Verification
REQ-026 Write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, slave all-ready, bresp=00 -> AW/W same cycle with those values, rsp_valid 3 cycles after accept, rsp_resp=00, rsp_write=1.
REQ-027 Write with awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held stable 4 cycles, single B accepted, rsp issued once.
REQ-028 Read addr=0x24, slave rdata=0x12345678, rresp=00 after 5 wait cycles -> rsp_rdata=0x12345678, rsp_write=0, arvalid low once arready seen.
REQ-029 rsp_ready held low 10 cycles -> rsp_valid and rsp_* stable, cmd_ready=0 throughout; new command accepted the cycle after rsp_ready.
REQ-030 rst pulsed while in WR_REQ -> all valids 0 immediately (async), no rsp_valid, next command proceeds normally.
REQ-031 With AXI4LITE_TIMEOUT_EN, TIMEOUT=16, slave never asserts rvalid -> after 16 cycles rready drops, rsp_resp=10, rsp_timeout=1.
